hc595_rx: RTL and testbench

Receive-side model of the 74HC595 serial display link: oversamples SHCP, STCP, DS and OE on the system clock and rebuilds the 16-bit `{segments, anodes}` word that the shift-register driver transmits. Sits in simulation benches and on-board loopback builds between the driver's `STCP`/`SHCP`/`DS`/`OE` pins and a checker or secondary display. Reports each latched word with a one-cycle valid strobe and flags frames whose shift count is not exactly WIDTH.

---
 rtl/hc595_rx.sv | 68 ++++++
 tb/tb_hc595_rx.sv | 113 +++++++++++
 2 files changed

// File: rtl/hc595_rx.sv
// hc595_rx: oversampling receiver that rebuilds the 74HC595 storage word from SHCP/STCP/DS/OE pins.
module hc595_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_shcp,
  input  logic             i_stcp,
  input  logic             i_ds,
  input  logic             i_oe,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic             o_en
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  logic [SYNC_STAGES-1:0] shcp_q, stcp_q, ds_q, oe_q;
  logic                   shcp_prev_q, stcp_prev_q;
  logic                   shcp_rise, stcp_rise;
  logic [WIDTH-1:0]       sr_q, sr_d, data_q, data_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   valid_q, valid_d, err_q, err_d;
  always_comb begin
    shcp_rise = shcp_q[SYNC_STAGES-1] & ~shcp_prev_q;
    stcp_rise = stcp_q[SYNC_STAGES-1] & ~stcp_prev_q;
    sr_d      = shcp_rise ? {sr_q[WIDTH-2:0], ds_q[SYNC_STAGES-1]} : sr_q;
    // a latch coinciding with a shift restarts the count at the shift it just took
    cnt_d     = stcp_rise ? (shcp_rise ? CW'(1) : '0)
              : (shcp_rise && cnt_q != CNT_MAX) ? cnt_q + CW'(1) : cnt_q;
    data_d    = stcp_rise ? sr_q : data_q;
    err_d     = stcp_rise ? (cnt_q != CNT_FULL) : err_q;
    valid_d   = stcp_rise;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shcp_q      <= '0;
      stcp_q      <= '0;
      ds_q        <= '0;
      oe_q        <= '1;
      shcp_prev_q <= 1'b0;
      stcp_prev_q <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      shcp_q      <= {shcp_q[SYNC_STAGES-2:0], i_shcp};
      stcp_q      <= {stcp_q[SYNC_STAGES-2:0], i_stcp};
      ds_q        <= {ds_q[SYNC_STAGES-2:0], i_ds};
      oe_q        <= {oe_q[SYNC_STAGES-2:0], i_oe};
      shcp_prev_q <= shcp_q[SYNC_STAGES-1];
      stcp_prev_q <= stcp_q[SYNC_STAGES-1];
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = err_q;
  assign o_en        = ~oe_q[SYNC_STAGES-1];
endmodule

// File: tb/tb_hc595_rx.sv
// tb_hc595_rx: directed self-checking bench for hc595_rx with hand-computed expected words.
module tb_hc595_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_shcp = 1'b0, i_stcp = 1'b0, i_ds = 1'b0, i_oe = 1'b1;
  logic [15:0] o_data;
  logic        o_valid, o_frame_err, o_en;
  int          n_assert = 0, n_fail = 0;
  logic [15:0] exp_pre;
  hc595_rx dut (
    .clk(clk), .rst_n(rst_n), .i_shcp(i_shcp), .i_stcp(i_stcp), .i_ds(i_ds), .i_oe(i_oe),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_en(o_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic shift_bit(input logic b);
    i_ds = b;
    repeat (4) @(negedge clk);
    i_shcp = 1'b1;
    repeat (4) @(negedge clk);
    i_shcp = 1'b0;
  endtask
  task automatic shift_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) shift_bit(w[i]);
  endtask
  task automatic latch(input logic [15:0] ed, input logic ee, input logic tied, input string tag);
    i_stcp = 1'b1;
    i_shcp = tied;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid_early"}, 32'(o_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_data"}, 32'(o_data), 32'(ed));
    chk({tag, "_err"}, 32'(o_frame_err), 32'(ee));
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    i_stcp = 1'b0;
    i_shcp = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_err", 32'(o_frame_err), 32'd0);
    chk("rst_en", 32'(o_en), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_en", 32'(o_en), 32'd0);
    i_oe = 1'b0;
    repeat (4) @(negedge clk);
    chk("en_on", 32'(o_en), 32'd1);
    shift_word(16'h3F0E);
    latch(16'h3F0E, 1'b0, 1'b0, "nominal");
    for (int i = 0; i < 15; i++) shift_bit(1'b1);
    latch(16'h7FFF, 1'b1, 1'b0, "short");
    shift_bit(1'b1);
    shift_word(16'hA5C3);
    latch(16'hA5C3, 1'b1, 1'b0, "long");
    shift_word(16'h1234);
    latch(16'h1234, 1'b0, 1'b0, "b2b_first");
    shift_word(16'hFEDC);
    latch(16'hFEDC, 1'b0, 1'b0, "b2b_second");
    exp_pre = 16'hFEDC;
    for (int k = 0; k < 17; k++) begin
      i_ds = 1'b1;
      @(negedge clk);
      latch(exp_pre, 1'b1, 1'b1, $sformatf("tied%0d", k + 1));
      exp_pre = {exp_pre[14:0], 1'b1};
    end
    chk("tied_final", 32'(o_data), 32'hFFFF);
    for (int i = 0; i < 8; i++) shift_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(o_data), 32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_err", 32'(o_frame_err), 32'd0);
    chk("midrst_en", 32'(o_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    shift_word(16'h00FF);
    latch(16'h00FF, 1'b0, 1'b0, "after_rst");
    chk("oe_pre", 32'(o_en), 32'd1);
    i_oe = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("oe_off%0d", k), 32'(o_en), k >= 2 ? 32'd0 : 32'd1);
      chk($sformatf("oe_off_data%0d", k), 32'(o_data), 32'h00FF);
    end
    i_oe = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("oe_on%0d", k), 32'(o_en), k >= 2 ? 32'd1 : 32'd0);
      chk($sformatf("oe_on_data%0d", k), 32'(o_data), 32'h00FF);
    end
    i_oe = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("oe_off2_%0d", k), 32'(o_en), k >= 2 ? 32'd0 : 32'd1);
      chk($sformatf("oe_off2_data%0d", k), 32'(o_data), 32'h00FF);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
